// File: rtl/gate_stim_seq_pkg.sv
// Shared types and constants for the gate stimulus sequencer.
// Holds the FSM state enum, vector-order mode encodings, bit positions of
// the gate-block result word and the 2-bit {a,b} vector tables for both orders.
package gate_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  localparam int unsigned RES_W   = 6;
  localparam int unsigned DWELL_W = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned IDX_W   = 2;

  // Result word bit positions, bit 0 = and.
  localparam int unsigned RES_AND   = 0;
  localparam int unsigned RES_OR    = 1;
  localparam int unsigned RES_NOT_A = 2;
  localparam int unsigned RES_XOR   = 3;
  localparam int unsigned RES_XNOR  = 4;
  localparam int unsigned RES_NAND  = 5;

  // {a,b} per sequence position; element 0 is applied first.
  localparam logic [3:0][1:0] VEC_BIN  = {2'b11, 2'b10, 2'b01, 2'b00};
  localparam logic [3:0][1:0] VEC_GRAY = {2'b10, 2'b11, 2'b01, 2'b00};

  // Look up the {a,b} vector for a sequence position in the given order.
  function automatic logic [1:0] vec_lookup(input logic mode, input logic [IDX_W-1:0] idx);
    return (mode == MODE_GRAY) ? VEC_GRAY[idx] : VEC_BIN[idx];
  endfunction

endpackage

// File: rtl/gate_stim_seq_if.sv
// Stimulus/response link between the sequencer and the gate block under test.
//   a, b : stimulus bits (sequencer -> gate block)
//   res  : gate block result word {nand,xnor,xor,not_a,or,and}
interface gate_stim_seq_if;
  import gate_stim_pkg::*;

  logic             a;
  logic             b;
  logic [RES_W-1:0] res;

  modport master (output a, output b, input res);
  modport slave  (input a, input b, output res);

endinterface

// File: rtl/gate_stim_seq_expect.sv
// Golden gate model: combinational expected result for the given a/b.
//   a, b     : stimulus bits currently applied
//   expected : expected result word in res bit order
module gate_expect
  import gate_stim_pkg::*;
(
  input  logic             a,
  input  logic             b,
  output logic [RES_W-1:0] expected
);

  always_comb begin
    expected            = '0;
    expected[RES_AND]   = a & b;
    expected[RES_OR]    = a | b;
    expected[RES_NOT_A] = ~a;
    expected[RES_XOR]   = a ^ b;
    expected[RES_XNOR]  = ~(a ^ b);
    expected[RES_NAND]  = ~(a & b);
  end

endmodule

// File: rtl/gate_stim_seq.sv
// Gate stimulus sequencer: walks {a,b} through all four input vectors
// (binary or gray order), holds each for DWELL cycles, compares the gate
// block result against a golden model at the end of each dwell, and counts
// mismatches over LOOPS passes.
//   clk, rst            : clock, synchronous active-high reset
//   start, abort, mode  : run request, run termination, vector order
//   stim                : a/b stimulus out, res result in
//   busy, done          : running flag, one-cycle completion pulse
//   vec_idx             : sequence position of the applied vector
//   err_cnt, err_flag   : saturating mismatch count, sticky mismatch flag
module gate_stim_seq
  import gate_stim_pkg::*;
#(
  parameter int unsigned DWELL = 10,
  parameter int unsigned LOOPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  gate_stim_seq_if.master  stim,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] vec_idx,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag
);

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic               mode_q, mode_d;
  logic [1:0]         ab_d;
  logic               busy_d, done_d, err_flag_d;
  logic [IDX_W-1:0]   vec_idx_d;
  logic [CNT_W-1:0]   err_cnt_d;

  logic [RES_W-1:0]   expected;
  logic               mismatch_c, last_dwell_c, last_vec_c, last_pass_c;

  gate_expect u_expect (
    .a        (stim.a),
    .b        (stim.b),
    .expected (expected)
  );

  assign mismatch_c   = (stim.res != expected);
  assign last_dwell_c = (dwell_q == DWELL_W'(DWELL - 1));
  assign last_vec_c   = (vec_idx == IDX_W'(3));
  assign last_pass_c  = (pass_q == CNT_W'(LOOPS - 1));

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    pass_d     = pass_q;
    mode_d     = mode_q;
    ab_d       = {stim.a, stim.b};
    vec_idx_d  = vec_idx;
    err_cnt_d  = err_cnt;
    err_flag_d = err_flag;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ab_d      = 2'b00;
        vec_idx_d = '0;
        dwell_d   = '0;
        pass_d    = '0;
        if (start) begin
          state_d    = ST_DRIVE;
          mode_d     = mode;
          ab_d       = vec_lookup(mode, IDX_W'(0));
          err_cnt_d  = '0;
          err_flag_d = 1'b0;
        end
      end

      ST_DRIVE: begin
        if (abort) begin
          // Abort wins over this cycle's compare and vector advance.
          state_d   = ST_IDLE;
          ab_d      = 2'b00;
          vec_idx_d = '0;
          dwell_d   = '0;
          pass_d    = '0;
        end else if (last_dwell_c) begin
          dwell_d = '0;
          if (mismatch_c) begin
            err_flag_d = 1'b1;
            if (err_cnt != {CNT_W{1'b1}}) err_cnt_d = err_cnt + CNT_W'(1);
          end
          if (last_vec_c) begin
            vec_idx_d = '0;
            if (last_pass_c) begin
              state_d = ST_DONE;
              ab_d    = 2'b00;
              pass_d  = '0;
              done_d  = 1'b1;
            end else begin
              pass_d = pass_q + CNT_W'(1);
              ab_d   = vec_lookup(mode_q, IDX_W'(0));
            end
          end else begin
            vec_idx_d = vec_idx + IDX_W'(1);
            ab_d      = vec_lookup(mode_q, vec_idx + IDX_W'(1));
          end
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        ab_d    = 2'b00;
      end

      default: begin
        state_d   = ST_IDLE;
        ab_d      = 2'b00;
        vec_idx_d = '0;
      end
    endcase

    busy_d = (state_d == ST_DRIVE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dwell_q  <= '0;
      pass_q   <= '0;
      mode_q   <= MODE_BIN;
      stim.a   <= 1'b0;
      stim.b   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      vec_idx  <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      pass_q   <= pass_d;
      mode_q   <= mode_d;
      stim.a   <= ab_d[1];
      stim.b   <= ab_d[0];
      busy     <= busy_d;
      done     <= done_d;
      vec_idx  <= vec_idx_d;
      err_cnt  <= err_cnt_d;
      err_flag <= err_flag_d;
    end
  end

endmodule
